// File: rtl/nco_phase_bank.sv
// nco_phase_bank: NCH-channel NCO phase accumulators with double-buffered FTW/POFF and an atomic commit.
// Define NCO_DITHER_EN to add a shared 16-bit LFSR dither on the output truncation path.
module nco_phase_bank #(
    parameter int NCH      = 4,
    parameter int ACC_W    = 28,
    parameter int FTW_W    = 28,
    parameter int PHASE_W  = 8,
    parameter int DITHER_W = 4,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     en,
    input  logic                     sync,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic                     wr_sel,
    input  logic [FTW_W-1:0]         wr_data,
    input  logic                     commit,
    output logic [NCH*PHASE_W-1:0]   phase_out,
    output logic                     phase_vld,
    output logic [NCH-1:0]           wrap
);
    if (FTW_W > ACC_W || PHASE_W > ACC_W || DITHER_W > ACC_W - PHASE_W) begin : g_bad_cfg
        $error("nco_phase_bank: illegal width configuration");
    end

    logic [FTW_W-1:0]       ftw_sh_q [NCH], ftw_sh_d [NCH], ftw_q [NCH], ftw_d [NCH];
    logic [PHASE_W-1:0]     poff_sh_q [NCH], poff_sh_d [NCH], poff_q [NCH], poff_d [NCH];
    logic [ACC_W-1:0]       acc_q [NCH], acc_d [NCH], out_acc [NCH];
    logic [ACC_W:0]         sum [NCH];
    logic [NCH-1:0]         carry_q, carry_d, wrap_q, wrap_d;
    logic [NCH*PHASE_W-1:0] phase_out_q, phase_out_d;
    logic                   vld_q, vld_d, phase_vld_q, phase_vld_d;
    logic [ACC_W-1:0]       dith;

`ifdef NCO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    // Fibonacci taps 16,14,13,11; advances only on en edges
    always_comb begin
        lfsr_d = en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        dith   = ACC_W'(lfsr_q[DITHER_W-1:0]);
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign dith = '0;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ftw_sh_d[i]  = (wr_en && !wr_sel && 32'(wr_ch) == i) ? wr_data : ftw_sh_q[i];
            poff_sh_d[i] = (wr_en && wr_sel && 32'(wr_ch) == i) ? wr_data[PHASE_W-1:0] : poff_sh_q[i];
            ftw_d[i]     = commit ? ftw_sh_q[i] : ftw_q[i];
            poff_d[i]    = commit ? poff_sh_q[i] : poff_q[i];
            sum[i]       = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(ftw_q[i]);
            acc_d[i]     = sync ? '0 : en ? sum[i][ACC_W-1:0] : acc_q[i];
            carry_d[i]   = en && !sync && sum[i][ACC_W];
            // dither only touches the output path, never the accumulator
            out_acc[i]   = acc_q[i] + dith;
            phase_out_d[i*PHASE_W +: PHASE_W] = out_acc[i][ACC_W-1 -: PHASE_W] + poff_q[i];
        end
        vld_d       = en && !sync;
        phase_vld_d = vld_q;
        wrap_d      = carry_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ftw_sh_q    <= '{default: '0};
            ftw_q       <= '{default: '0};
            poff_sh_q   <= '{default: '0};
            poff_q      <= '{default: '0};
            acc_q       <= '{default: '0};
            carry_q     <= '0;
            wrap_q      <= '0;
            vld_q       <= 1'b0;
            phase_vld_q <= 1'b0;
            phase_out_q <= '0;
        end else begin
            ftw_sh_q    <= ftw_sh_d;
            ftw_q       <= ftw_d;
            poff_sh_q   <= poff_sh_d;
            poff_q      <= poff_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            wrap_q      <= wrap_d;
            vld_q       <= vld_d;
            phase_vld_q <= phase_vld_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign phase_out = phase_out_q;
    assign phase_vld = phase_vld_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_nco_phase_bank.sv
// tb_nco_phase_bank: directed scenarios plus random traffic against an arithmetic reference model.
module tb_nco_phase_bank;
    localparam int NCH = 4, ACC_W = 28, FTW_W = 28, PHASE_W = 8, DITHER_W = 4;
    localparam longint M = 64'd1 << ACC_W;
    localparam longint LSB = 64'd1 << (ACC_W - PHASE_W);

    logic clk = 0, clrn = 0, en = 0, sync = 0, wr_en = 0, wr_sel = 0, commit = 0;
    logic [1:0] wr_ch = 0;
    logic [FTW_W-1:0] wr_data = 0;
    logic [NCH*PHASE_W-1:0] phase_out;
    logic phase_vld;
    logic [NCH-1:0] wrap;

    nco_phase_bank #(.NCH(NCH), .ACC_W(ACC_W), .FTW_W(FTW_W), .PHASE_W(PHASE_W), .DITHER_W(DITHER_W)) dut (
        .clk(clk), .clrn(clrn), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_sel(wr_sel), .wr_data(wr_data), .commit(commit),
        .phase_out(phase_out), .phase_vld(phase_vld), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    longint sh_f [NCH], sh_p [NCH], act_f [NCH], act_p [NCH], acc [NCH], e_phase [NCH];
    longint e_vld, vld_p, lfsr;
    bit [NCH-1:0] car_p, e_wrap;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            sh_f[i] = 0; sh_p[i] = 0; act_f[i] = 0; act_p[i] = 0; acc[i] = 0; e_phase[i] = 0;
        end
        e_vld = 0; vld_p = 0; car_p = '0; e_wrap = '0; lfsr = 16'hACE1;
    endtask

    function automatic longint lfsr_next(longint l);
        int taps[4] = '{16, 14, 13, 11};
        longint fb = 0;
        for (int k = 0; k < 4; k++) fb ^= (l >> (taps[k] - 1)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    task automatic compare_all(string tag);
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_phase%0d", tag, i), phase_out[i*PHASE_W +: PHASE_W], e_phase[i]);
        check({tag, "_vld"}, phase_vld, e_vld);
        check({tag, "_wrap"}, wrap, e_wrap);
    endtask

    task automatic tick();
        longint d, s;
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            d = acc[i];
`ifdef NCO_DITHER_EN
            d = (d + (lfsr % (64'd1 << DITHER_W))) % M;
`endif
            e_phase[i] = (d / LSB + act_p[i]) % (64'd1 << PHASE_W);
        end
        e_vld = vld_p;
        e_wrap = car_p;
        vld_p = (en && !sync) ? 1 : 0;
        for (int i = 0; i < NCH; i++) begin
            s = acc[i] + act_f[i];
            car_p[i] = en && !sync && s >= M;
            if (sync) acc[i] = 0;
            else if (en) acc[i] = s % M;
        end
        if (commit) for (int i = 0; i < NCH; i++) begin act_f[i] = sh_f[i]; act_p[i] = sh_p[i]; end
        if (wr_en && wr_ch < NCH) begin
            if (wr_sel) sh_p[wr_ch] = wr_data % (64'd1 << PHASE_W);
            else sh_f[wr_ch] = wr_data;
        end
`ifdef NCO_DITHER_EN
        if (en) lfsr = lfsr_next(lfsr);
`endif
        #1;
        compare_all("cyc");
    endtask

    task automatic cyc(bit e, bit s, bit w, logic [1:0] ch, bit sel, logic [FTW_W-1:0] dat, bit c);
        en = e; sync = s; wr_en = w; wr_ch = ch; wr_sel = sel; wr_data = dat; commit = c;
        tick();
    endtask

    task automatic async_reset(string tag);
        clrn = 0;
        #1;
        for (int i = 0; i < NCH; i++) e_phase[i] = 0;
        e_vld = 0; e_wrap = '0;
        compare_all(tag);
        #2 clrn = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("reset");
        #5 clrn = 1;
        // ramp on ch0: one phase LSB per en, wrap after 256 steps
        cyc(0, 0, 1, 0, 0, 28'h0100000, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (260) cyc(1, 0, 0, 0, 0, 0, 0);
        // atomic commit of ch1/ch2
        cyc(1, 0, 1, 1, 0, 28'h0200000, 0);
        cyc(1, 0, 1, 2, 0, 28'h0400000, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
        // commit colliding with a shadow write
        cyc(1, 0, 1, 0, 0, 28'h0300000, 0);
        cyc(1, 0, 1, 0, 0, 28'h0050000, 1);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0);
        // POFF on ch3 then sync
        cyc(0, 0, 1, 3, 0, 28'h0100000, 0);
        cyc(0, 0, 1, 3, 1, 28'h0000080, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("sync_ch3_poff", phase_out[3*PHASE_W +: PHASE_W], 8'h80);
        check("sync_vld_low", phase_vld, 0);
        check("sync_wrap_low", wrap, 0);
        async_reset("midreset");
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int n = 0; n < 1500; n++)
            cyc($urandom_range(3) != 0, $urandom_range(19) == 0, $urandom_range(4) < 2,
                2'($urandom_range(3)), 1'($urandom_range(1)), FTW_W'($urandom),
                $urandom_range(9) == 0);
        async_reset("endreset");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
